// File: rtl/text_pixel_gen_pkg.sv
// Shared text-mode geometry, address widths and pipeline side-band record.
// Also stands in for the vga_defs.vh constant set: H_VISIBLE, V_VISIBLE, CHAR_W, CHAR_H, COLS, ROWS.
package text_pixel_gen_pkg;

  localparam int H_VISIBLE       = 640;
  localparam int V_VISIBLE       = 480;
  localparam int CHAR_W          = 8;
  localparam int CHAR_H          = 16;
  localparam int COLS            = H_VISIBLE / CHAR_W;
  localparam int ROWS            = V_VISIBLE / CHAR_H;
  localparam int TB_ADDR_WIDTH   = $clog2(COLS * ROWS);
  localparam int PIX_X_BITS      = $clog2(CHAR_W);
  localparam int LINE_BITS       = $clog2(CHAR_H);
  localparam int FONT_ADDR_WIDTH = 7 + LINE_BITS;
  localparam int CELL_COL_BITS   = 10 - PIX_X_BITS;
  localparam int CELL_ROW_BITS   = 5;

  localparam logic SYNC_IDLE = 1'b1;

  typedef struct packed {
    logic                  active;
    logic                  hsync;
    logic                  vsync;
    logic [PIX_X_BITS-1:0] col;
  } side_t;

  localparam side_t SIDE_RESET = '{active: 1'b0, hsync: SYNC_IDLE, vsync: SYNC_IDLE, col: '0};

  // row*80 as two shifts; only valid while COLS stays 80.
  function automatic logic [TB_ADDR_WIDTH-1:0] cell_addr(
    input logic [CELL_ROW_BITS-1:0] row,
    input logic [CELL_COL_BITS-1:0] col
  );
    logic [TB_ADDR_WIDTH-1:0] r;
    logic [TB_ADDR_WIDTH-1:0] c;
    r = TB_ADDR_WIDTH'(row);
    c = TB_ADDR_WIDTH'(col);
    return (r << 6) + (r << 4) + c;
  endfunction

endpackage

// File: rtl/cursor_blink.sv
// Blinking cursor: counts vsync falling edges, blink phase from counter MSB, cell compare.
// Present only when CURSOR_EN is defined.
`ifdef CURSOR_EN
module cursor_blink
  import text_pixel_gen_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     vsync_i,
  input  logic [CELL_COL_BITS-1:0] cell_col_i,
  input  logic [CELL_ROW_BITS-1:0] cell_row_i,
  input  logic [CELL_COL_BITS-1:0] cursor_col_i,
  input  logic [CELL_ROW_BITS-1:0] cursor_row_i,
  output logic                     invert_o
);

  logic       vsync_q;
  logic [4:0] frame_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vsync_q   <= SYNC_IDLE;
      frame_cnt <= '0;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_q && !vsync_i) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Counter MSB toggles every 16 frames, so the cursor starts hidden after reset.
  assign invert_o = frame_cnt[4]
                  && (cell_col_i == cursor_col_i)
                  && (cell_row_i == cursor_row_i);

endmodule
`endif

// File: rtl/text_pixel_gen.sv
// Text-mode pixel pipeline: coordinates -> text address -> font address -> pixel, sync/active delayed alongside.
// Four register stages, no stall; optional blinking cursor under CURSOR_EN.
module text_pixel_gen
  import text_pixel_gen_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [9:0]                 hcount_i,
  input  logic [9:0]                 vcount_i,
  input  logic                       active_i,
  input  logic                       hsync_i,
  input  logic                       vsync_i,
  output logic [TB_ADDR_WIDTH-1:0]   tb_addr_o,
  input  logic [7:0]                 char_i,
  output logic [FONT_ADDR_WIDTH-1:0] font_addr_o,
  input  logic [7:0]                 font_row_i,
  output logic                       pix_o,
  output logic                       active_o,
  output logic                       hsync_o,
  output logic                       vsync_o
`ifdef CURSOR_EN
  ,
  input  logic [CELL_COL_BITS-1:0]   cursor_col_i,
  input  logic [CELL_ROW_BITS-1:0]   cursor_row_i
`endif
);

  side_t                side_d1, side_d2, side_d3;
  logic [LINE_BITS-1:0] line_d1, line_d2;
  logic                 font_bit;
  logic                 cursor_inv;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tb_addr_o <= '0;
      side_d1   <= SIDE_RESET;
      side_d2   <= SIDE_RESET;
      side_d3   <= SIDE_RESET;
      line_d1   <= '0;
      line_d2   <= '0;
      pix_o     <= 1'b0;
      active_o  <= 1'b0;
      hsync_o   <= SYNC_IDLE;
      vsync_o   <= SYNC_IDLE;
    end else begin
      // Off-screen coordinates still address the buffer; active masks the result.
      tb_addr_o <= cell_addr(vcount_i[8:4], hcount_i[9:3]);
      side_d1   <= '{active: active_i, hsync: hsync_i, vsync: vsync_i,
                     col: hcount_i[PIX_X_BITS-1:0]};
      line_d1   <= vcount_i[LINE_BITS-1:0];
      side_d2   <= side_d1;
      line_d2   <= line_d1;
      side_d3   <= side_d2;
      pix_o     <= side_d3.active & (font_bit ^ cursor_inv);
      active_o  <= side_d3.active;
      hsync_o   <= side_d3.hsync;
      vsync_o   <= side_d3.vsync;
    end
  end

  // Bit 7 of the code is dropped so codes 128-255 alias onto the 128-glyph font.
  assign font_addr_o = {char_i[6:0], line_d2};
  assign font_bit    = font_row_i[side_d3.col];

`ifdef CURSOR_EN
  logic [CELL_COL_BITS-1:0] cell_col_d1, cell_col_d2, cell_col_d3;
  logic [CELL_ROW_BITS-1:0] cell_row_d1, cell_row_d2, cell_row_d3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cell_col_d1 <= '0;
      cell_col_d2 <= '0;
      cell_col_d3 <= '0;
      cell_row_d1 <= '0;
      cell_row_d2 <= '0;
      cell_row_d3 <= '0;
    end else begin
      cell_col_d1 <= hcount_i[9:3];
      cell_row_d1 <= vcount_i[8:4];
      cell_col_d2 <= cell_col_d1;
      cell_row_d2 <= cell_row_d1;
      cell_col_d3 <= cell_col_d2;
      cell_row_d3 <= cell_row_d2;
    end
  end

  cursor_blink u_cursor_blink (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .vsync_i      (vsync_i),
    .cell_col_i   (cell_col_d3),
    .cell_row_i   (cell_row_d3),
    .cursor_col_i (cursor_col_i),
    .cursor_row_i (cursor_row_i),
    .invert_o     (cursor_inv)
  );
`else
  assign cursor_inv = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{vcount_i[9], char_i[7]};

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: memory models, table vectors, random traffic vs. arithmetic reference.
module tb_text_pixel_gen;
  import text_pixel_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  hcount, vcount;
  logic        active, hsync, vsync;
  logic [11:0] tb_addr;
  logic [7:0]  char_d;
  logic [10:0] font_addr;
  logic [7:0]  font_row;
  logic        pix, act_o, hs_o, vs_o;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  always #20 clk = ~clk;

  text_pixel_gen dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .hcount_i    (hcount),
    .vcount_i    (vcount),
    .active_i    (active),
    .hsync_i     (hsync),
    .vsync_i     (vsync),
    .tb_addr_o   (tb_addr),
    .char_i      (char_d),
    .font_addr_o (font_addr),
    .font_row_i  (font_row),
    .pix_o       (pix),
    .active_o    (act_o),
    .hsync_o     (hs_o),
    .vsync_o     (vs_o)
`ifdef CURSOR_EN
    ,
    .cursor_col_i (cur_col),
    .cursor_row_i (cur_row)
`endif
  );

  // Text buffer and font ROM, both one-clock registered reads.
  logic [7:0] tbuf [4096];
  logic [7:0] font [2048];
  always @(posedge clk) begin
    char_d   <= tbuf[tb_addr];
    font_row <= font[font_addr];
  end

  typedef struct packed {
    logic pix;
    logic act;
    logic hs;
    logic vs;
  } exp_t;

  typedef struct {
    int   h;
    int   v;
    logic a, hs, vs;
    logic exp_pix, exp_act, exp_hs, exp_vs;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   frames = 0;
  logic prev_vs = 1'b1;

  function automatic logic model_pix(input int h, input int v, input logic a);
    int         row, col, addr;
    logic [7:0] code, fr;
    logic       b;
    if (!a) return 1'b0;
    row  = (v / 16) % 32;
    col  = h / 8;
    addr = (row * 80 + col) % 4096;
    code = tbuf[addr];
    fr   = font[(int'(code) % 128) * 16 + v % 16];
    b    = fr[h % 8];
`ifdef CURSOR_EN
    if (((frames / 16) % 2) == 1 && col == int'(cur_col) && row == int'(cur_row)) b = !b;
`endif
    return b;
  endfunction

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // One pixel clock: compare the output due now, then present new inputs.
  task automatic tick(input int h, input int v, input logic a, input logic hs, input logic vs,
                      input logic ovr, input exp_t xe);
    exp_t e;
    @(negedge clk);
    if (q.size() >= 4) begin
      e = q.pop_front();
      check1("pix_o", 16'(pix), 16'(e.pix));
      check1("active_o", 16'(act_o), 16'(e.act));
      check1("hsync_o", 16'(hs_o), 16'(e.hs));
      check1("vsync_o", 16'(vs_o), 16'(e.vs));
    end
    hcount = 10'(h);
    vcount = 10'(v);
    active = a;
    hsync  = hs;
    vsync  = vs;
    if (!vs && prev_vs) frames++;
    prev_vs = vs;
    if (ovr) e = xe;
    else e = '{pix: model_pix(h, v, a), act: a, hs: hs, vs: vs};
    q.push_back(e);
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clk);
    rstn   = 1'b0;
    active = 1'b1;
    hsync  = 1'b0;
    vsync  = 1'b1;
    q.delete();
    repeat (hold) begin
      @(negedge clk);
      check1("rst_pix", 16'(pix), 16'd0);
      check1("rst_active", 16'(act_o), 16'd0);
      check1("rst_hsync", 16'(hs_o), 16'd1);
      check1("rst_vsync", 16'(vs_o), 16'd1);
      check1("rst_tb_addr", 16'(tb_addr), 16'd0);
    end
    repeat (3) q.push_back('{pix: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1});
    @(negedge clk);
    rstn    = 1'b1;
    hcount  = 10'd0;
    vcount  = 10'd0;
    frames  = 0;
    prev_vs = 1'b1;
    q.push_back('{pix: model_pix(0, 0, 1'b1), act: 1'b1, hs: 1'b0, vs: 1'b1});
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      tick(int'($urandom_range(799)), int'($urandom_range(524)), 1'($urandom),
           1'($urandom), 1'($urandom), 1'b0, '0);
    end
  endtask

  vec_t tbl[22];

  initial begin
    rstn = 1'b0; hcount = '0; vcount = '0; active = 1'b0; hsync = 1'b1; vsync = 1'b1;
    cur_col = 7'd127; cur_row = 5'd31;
    for (int i = 0; i < 4096; i++) tbuf[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);

    apply_reset(3);

    // Address path: cell (col 2, row 2) -> 162; code 0x41 line 3 -> 0x413.
    tbuf[162] = 8'h41;
    tick(17, 35, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(17, 35, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check1("tb_addr_17_35", 16'(tb_addr), 16'd162);
    tick(17, 35, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check1("font_addr_41", 16'(font_addr), 16'h413);
    tbuf[162] = 8'hC1;
    tick(17, 35, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check1("font_addr_C1_alias", 16'(font_addr), 16'h413);
    tick(639, 479, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(639, 479, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check1("tb_addr_last_cell", 16'(tb_addr), 16'd2399);
    tick(639, 479, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check1("font_addr_line15", 16'({tbuf[2399][6:0], 4'd15}), 16'(font_addr));

    // Table: font row 0x81 across a cell, blanking with 0xFF, sync pulses.
    tbuf[161] = 8'h41; font[11'h413] = 8'h81;
    tbuf[162] = 8'hC2; font[11'h423] = 8'hFF;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{8 + i, 35, 1'b1, 1'b1, 1'b1, (i == 0 || i == 7), 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[8 + i] = '{16 + i, 35, 1'b0, (i != 2), 1'b1, 1'b0, 1'b0, (i != 2), 1'b1};
    for (int i = 0; i < 4; i++)
      tbl[16 + i] = '{16 + i, 35, 1'b1, 1'b1, (i != 3), 1'b1, 1'b1, 1'b1, (i != 3)};
    tbl[20] = '{700, 35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[21] = '{23, 35, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 22; i++) begin
      tick(tbl[i].h, tbl[i].v, tbl[i].a, tbl[i].hs, tbl[i].vs, 1'b1,
           '{pix: tbl[i].exp_pix, act: tbl[i].exp_act, hs: tbl[i].exp_hs, vs: tbl[i].exp_vs});
    end

    random_run(1500);
    apply_reset(2);
    random_run(300);

`ifdef CURSOR_EN
    apply_reset(2);
    cur_col = 7'd2; cur_row = 5'd2;
    tbuf[162] = 8'h20; font[11'h203] = 8'h00;
    repeat (16) begin
      tick(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 8; i++)
      tick(16 + i, 35, 1'b1, 1'b1, 1'b1, 1'b1, '{pix: 1'b1, act: 1'b1, hs: 1'b1, vs: 1'b1});
    repeat (16) begin
      tick(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 8; i++)
      tick(16 + i, 35, 1'b1, 1'b1, 1'b1, 1'b1, '{pix: 1'b0, act: 1'b1, hs: 1'b1, vs: 1'b1});
`endif

    repeat (4) tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
